// File: rtl/seq_multiplier.sv
// seq_multiplier: N-iteration shift-add unsigned multiplier with start/busy/done handshake.
module seq_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] result,
    output logic           busy,
    output logic           done
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] mcand_q, mcand_d, acc_q, acc_d, result_q, result_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic           busy_q, busy_d, done_q, done_d;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                mcand_d  = {{N{1'b0}}, multiplicand};
                mplier_d = multiplier;
                acc_d    = '0;
                cnt_d    = CW'(N);
                state_d  = BUSY;
            end
            BUSY: begin
                // multiplicand walks left while the multiplier is consumed LSB-first
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    result_d = acc_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: randomized and directed checks of seq_multiplier against an arithmetic model.
module tb_seq_multiplier;
    localparam int N = 8;
    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   multiplicand = '0;
    logic [N-1:0]   multiplier = '0;
    logic [2*N-1:0] result;
    logic           busy, done;
    int tests = 0;
    int fails = 0;

    seq_multiplier #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Observes one operation; k counts falling edges after the accepting edge E0.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int rp,
                          input logic [N-1:0] a2, input logic [N-1:0] b2, input int kmax,
                          output int first_done, output int n_done, output int n_busy,
                          output int n_change, output logic [2*N-1:0] res);
        logic [2*N-1:0] r0;
        @(negedge clk);
        r0 = result;
        first_done = -1; n_done = 0; n_busy = 0; n_change = 0;
        start = 1'b1; multiplicand = a; multiplier = b;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= kmax; k++) begin
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (busy === 1'b1) n_busy++;
            if (k < N && result !== r0) n_change++;
            if (k == rp - 1) begin start = 1'b1; multiplicand = a2; multiplier = b2; end
            if (k == rp) start = 1'b0;
            if (k < kmax) @(negedge clk);
        end
        res = result;
    endtask

    task automatic test_reset;
        #1;
        tests++; if (result !== '0) begin fails++; $display("FAIL reset_result got %0d want 0", result); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic check_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
        int fd, nd, nb, nc;
        logic [2*N-1:0] res, exp;
        exp = (2*N)'(a) * (2*N)'(b);
        run_op(a, b, -1, '0, '0, N + 3, fd, nd, nb, nc, res);
        tests++; if (res !== exp) begin fails++; $display("FAIL %s_result %0dx%0d got %0d want %0d", name, a, b, res, exp); end
        tests++; if (fd !== N) begin fails++; $display("FAIL %s_latency got %0d want %0d", name, fd, N); end
        tests++; if (nd !== 1) begin fails++; $display("FAIL %s_done_count got %0d want 1", name, nd); end
        tests++; if (nb !== N + 1) begin fails++; $display("FAIL %s_busy_cycles got %0d want %0d", name, nb, N + 1); end
        tests++; if (nc !== 0) begin fails++; $display("FAIL %s_result_early_change got %0d want 0", name, nc); end
    endtask

    task automatic test_directed;
        check_op("13x11", 8'd13, 8'd11);
        check_op("255x255", 8'd255, 8'd255);
        check_op("0x200", 8'd0, 8'd200);
        check_op("200x0", 8'd200, 8'd0);
        check_op("1x1", 8'd1, 8'd1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++)
            check_op("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_ignore_start;
        int fd, nd, nb, nc;
        logic [2*N-1:0] res;
        run_op(8'd7, 8'd6, 3, 8'd9, 8'd9, 2*N + 4, fd, nd, nb, nc, res);
        tests++; if (res !== 16'd42) begin fails++; $display("FAIL ignore_result got %0d want 42", res); end
        tests++; if (nd !== 1) begin fails++; $display("FAIL ignore_done_count got %0d want 1", nd); end
        tests++; if (fd !== N) begin fails++; $display("FAIL ignore_latency got %0d want %0d", fd, N); end
        tests++; if (nb !== N + 1) begin fails++; $display("FAIL ignore_busy_cycles got %0d want %0d", nb, N + 1); end
    endtask

    task automatic test_back_to_back;
        int nd = 0;
        int dk[2];
        logic [2*N-1:0] dr[2];
        @(negedge clk);
        start = 1'b1; multiplicand = 8'd3; multiplier = 8'd5;
        for (int k = 0; k < 40 && nd < 2; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dk[nd] = k; dr[nd] = result; nd++;
                if (nd == 1) begin multiplicand = 8'd4; multiplier = 8'd4; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        tests++; if (nd !== 2) begin fails++; $display("FAIL b2b_done_count got %0d want 2", nd); end
        if (nd == 2) begin
            tests++; if (dr[0] !== 16'd15) begin fails++; $display("FAIL b2b_first got %0d want 15", dr[0]); end
            tests++; if (dr[1] !== 16'd16) begin fails++; $display("FAIL b2b_second got %0d want 16", dr[1]); end
            tests++; if (dk[1] - dk[0] !== N + 2) begin fails++; $display("FAIL b2b_period got %0d want %0d", dk[1] - dk[0], N + 2); end
        end
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_abort;
        int fd = -1;
        int nd = 0;
        int nd_rst = 0;
        logic b0;
        @(negedge clk);
        start = 1'b1; multiplicand = 8'd100; multiplier = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        tests++; if (result !== '0) begin fails++; $display("FAIL abort_result got %0d want 0", result); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", done); end
        start = 1'b1; multiplicand = 8'd2; multiplier = 8'd2;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) nd_rst++;
        end
        reset = 1'b1;
        @(negedge clk);
        b0 = busy;
        start = 1'b0;
        for (int k = 0; k <= N + 3; k++) begin
            if (done === 1'b1) begin nd++; if (fd < 0) fd = k; end
            if (k < N + 3) @(negedge clk);
        end
        tests++; if (nd_rst !== 0) begin fails++; $display("FAIL abort_held_outputs got %0d want 0", nd_rst); end
        tests++; if (b0 !== 1'b1) begin fails++; $display("FAIL first_edge_accept got %b want 1", b0); end
        tests++; if (fd !== N) begin fails++; $display("FAIL post_reset_latency got %0d want %0d", fd, N); end
        tests++; if (nd !== 1) begin fails++; $display("FAIL post_reset_done_count got %0d want 1", nd); end
        tests++; if (result !== 16'd4) begin fails++; $display("FAIL post_reset_result got %0d want 4", result); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_back_to_back;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
